// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu: load/store unit for the single-issue RV32I core.
//
// Accepts one memory operation at a time from the execute stage, performs a
// single req/ack data-memory transaction, and returns a sign/zero-extended
// load result (or an error) to writeback. All outputs are registered.
//
// Parameters
//   ACK_TIMEOUT  cycles mem_req may wait for mem_ack before aborting with an
//                error; 0 disables the timeout.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                execute-stage handshake
//   is_store, funct3, addr,
//   store_data, rd_idx                 operation descriptor
//   mem_req/mem_we/mem_addr/
//   mem_wstrb/mem_wdata                data-memory request (held until ack)
//   mem_ack/mem_rdata                  data-memory completion
//   resp_valid/resp_ready              writeback handshake
//   resp_rd/resp_data/resp_err         writeback result
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new operation
// REQ   | bus request outstanding, waiting for mem_ack (or timeout)
// RESP  | result held on resp_* until writeback takes it
// ---------------------------------------------------------------------------
module lsu #(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_idx,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;

    // Request decode (combinational on the execute-stage inputs).
    logic        op_legal;
    logic        op_aligned;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;

    always_comb begin
        if (is_store) begin
            op_legal = (funct3 <= 3'd2);
        end else begin
            op_legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        end

        // funct3[1:0] encodes access size for both loads and stores.
        case (funct3[1:0])
            2'b01:   op_aligned = ~addr[0];
            2'b10:   op_aligned = (addr[1:0] == 2'b00);
            default: op_aligned = 1'b1;
        endcase

        case (funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << addr[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_strb  = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    // Load extraction uses the lane and funct3 latched at accept.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (f3_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd2:    ld_ext = mem_rdata;
            3'd4:    ld_ext = {24'd0, ld_byte};
            3'd5:    ld_ext = {16'd0, ld_half};
            default: ld_ext = 32'd0;
        endcase
    end

    // cnt_q holds the number of REQ cycles already completed without an ack.
    logic timeout_hit;
    assign timeout_hit = (ACK_TIMEOUT != 0) && ((cnt_q + 32'd1) == ACK_TIMEOUT);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rd_d    = resp_rd_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        lane_d       = lane_q;
        f3_d         = f3_q;
        rd_d         = rd_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (op_legal && op_aligned) begin
                        state_d     = ST_REQ;
                        cnt_d       = 32'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wstrb_d = is_store ? st_strb : 4'd0;
                        mem_wdata_d = is_store ? st_wdata : 32'd0;
                        lane_d      = addr[1:0];
                        f3_d        = funct3;
                        rd_d        = is_store ? 5'd0 : rd_idx;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rd_d    = 5'd0;
                        resp_data_d  = 32'd0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack || timeout_hit) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = 32'd0;
                    mem_wstrb_d  = 4'd0;
                    mem_wdata_d  = 32'd0;
                    resp_valid_d = 1'b1;
                    // An ack in the last allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        resp_err_d  = 1'b0;
                        resp_rd_d   = rd_q;
                        resp_data_d = mem_we_q ? 32'd0 : ld_ext;
                    end else begin
                        resp_err_d  = 1'b1;
                        resp_rd_d   = 5'd0;
                        resp_data_d = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rd_d    = 5'd0;
                    resp_data_d  = 32'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 32'd0;
            req_ready_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wstrb_q  <= 4'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rd_q    <= 5'd0;
            resp_data_q  <= 32'd0;
            resp_err_q   <= 1'b0;
            lane_q       <= 2'd0;
            f3_q         <= 3'd0;
            rd_q         <= 5'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rd_q    <= resp_rd_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            lane_q       <= lane_d;
            f3_q         <= f3_d;
            rd_q         <= rd_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rd    = resp_rd_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule
